// File: rtl/muldiv_hilo_if.sv
// Request/result bundle between the MCPU controller and the HI/LO multiply/divide unit.
// The controller drives the request side; the unit drives HI/LO and status.
interface muldiv_hilo_if;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] src0_i;
  logic [31:0] src1_i;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        busy_o;
  logic        done_o;

  modport master (
    output start_i, op_i, src0_i, src1_i,
    input  hi_o, lo_o, busy_o, done_o
  );

  modport slave (
    input  start_i, op_i, src0_i, src1_i,
    output hi_o, lo_o, busy_o, done_o
  );
endinterface

// File: rtl/muldiv_hilo.sv
// Iterative 32-bit multiply/divide with the architectural HI/LO pair.
// Each mult/div takes 32 shift/add or shift/subtract steps plus one sign-fix step.
module muldiv_hilo (
  input  logic          clk,
  input  logic          rst,
  muldiv_hilo_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic [31:0] opb;
  logic [31:0] acc;
  logic [31:0] low;
  logic [31:0] orig_src0;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        is_div;
  logic        neg_res;
  logic        neg_rem;
  logic        div_zero;
  logic        done_q;

  logic [32:0] add_sum;
  logic [32:0] rem_shift;
  logic [32:0] trial;
  logic [63:0] prod_fix;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;
  logic        op_signed;
  logic [31:0] a_in;
  logic [31:0] b_in;

  // Signed ops run on magnitudes; the sign is reapplied in FIX.
  function automatic logic [31:0] mag(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? -v : v;
  endfunction

  always_comb begin
    op_signed = ~bus.op_i[0];
    a_in      = mag(bus.src0_i, op_signed);
    b_in      = mag(bus.src1_i, op_signed);
    add_sum   = {1'b0, acc} + (low[0] ? {1'b0, opb} : 33'd0);
    rem_shift = {acc, low[31]};
    trial     = rem_shift - {1'b0, opb};
    prod_fix  = neg_res ? -{acc, low} : {acc, low};
    quot_fix  = neg_res ? -low : low;
    rem_fix   = neg_rem ? -acc : acc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 5'd0;
      opb       <= 32'd0;
      acc       <= 32'd0;
      low       <= 32'd0;
      orig_src0 <= 32'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      is_div    <= 1'b0;
      neg_res   <= 1'b0;
      neg_rem   <= 1'b0;
      div_zero  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start_i) begin
            if (!bus.op_i[2]) begin
              // acc/low hold {product hi, multiplier} for mult and {rem, quot} for div.
              is_div    <= bus.op_i[1];
              acc       <= 32'd0;
              low       <= bus.op_i[1] ? a_in : b_in;
              opb       <= bus.op_i[1] ? b_in : a_in;
              neg_res   <= op_signed & (bus.src0_i[31] ^ bus.src1_i[31]);
              neg_rem   <= op_signed & bus.src0_i[31];
              div_zero  <= (bus.src1_i == 32'd0);
              orig_src0 <= bus.src0_i;
              cnt       <= 5'd0;
              state     <= CALC;
            end else if (bus.op_i == 3'd4) begin
              hi_q <= bus.src0_i;
            end else if (bus.op_i == 3'd5) begin
              lo_q <= bus.src0_i;
            end
          end
        end
        CALC: begin
          if (is_div) begin
            if (!trial[32]) begin
              acc <= trial[31:0];
              low <= {low[30:0], 1'b1};
            end else begin
              acc <= rem_shift[31:0];
              low <= {low[30:0], 1'b0};
            end
          end else begin
            acc <= add_sum[32:1];
            low <= {add_sum[0], low[31:1]};
          end
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            state <= FIX;
          end
        end
        FIX: begin
          if (is_div && div_zero) begin
            hi_q <= orig_src0;
            lo_q <= 32'hFFFF_FFFF;
          end else if (is_div) begin
            hi_q <= rem_fix;
            lo_q <= quot_fix;
          end else begin
            hi_q <= prod_fix[63:32];
            lo_q <= prod_fix[31:0];
          end
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.hi_o   = hi_q;
  assign bus.lo_o   = lo_q;
  assign bus.busy_o = (state != IDLE);
  assign bus.done_o = done_q;

endmodule

// File: tb/tb_muldiv_hilo.sv
// Scoreboard bench for muldiv_hilo: directed corner cases plus random ops,
// expected HI/LO computed with plain 64-bit arithmetic.
module tb_muldiv_hilo;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  muldiv_hilo_if bus ();

  muldiv_hilo dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          vectors     = 0;
  int          miscompares = 0;
  logic [63:0] exp_q[$];
  logic [31:0] model_hi = 32'd0;
  logic [31:0] model_lo = 32'd0;
  logic [63:0] mon_exp;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Returns {HI, LO} from the architectural definition of each op.
  function automatic logic [63:0] refResult(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      q;
    longint      r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = 64'd0;
    case (op)
      3'd0: p = 64'(sa * sb);
      3'd1: p = {32'd0, a} * {32'd0, b};
      3'd2: begin
        if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      3'd3: begin
        if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
        else p = {a % b, a / b};
      end
      default: p = 64'd0;
    endcase
    return p;
  endfunction

  // Monitor: every done_o pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus.done_o) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_done: got done_o=1, expected no pending result");
      end else begin
        mon_exp = exp_q.pop_front();
        checkOutput("hilo_result", {bus.hi_o, bus.lo_o}, mon_exp);
      end
    end
  end

  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input int mt_at, input int rst_at);
    logic [63:0] old;
    logic [63:0] seen;
    int          cyc;
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.src0_i  = a;
    bus.src1_i  = b;
    old = {model_hi, model_lo};
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    if (op <= 3'd3) begin
      exp_q.push_back(refResult(op, a, b));
      {model_hi, model_lo} = refResult(op, a, b);
      seen = old;
      cyc  = 0;
      while (bus.busy_o && cyc < 40) begin
        if ({bus.hi_o, bus.lo_o} !== old) seen = {bus.hi_o, bus.lo_o};
        if (cyc == mt_at) begin
          bus.start_i = 1'b1;
          bus.op_i    = 3'd5;
          bus.src0_i  = $urandom;
        end
        if (cyc == rst_at) rst = 1'b1;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        cyc++;
        if (rst) begin
          rst = 1'b0;
          exp_q.delete();
          model_hi = 32'd0;
          model_lo = 32'd0;
          checkOutput("rst_busy", 64'(bus.busy_o), 64'd0);
          checkOutput("rst_done", 64'(bus.done_o), 64'd0);
          checkOutput("rst_hilo", {bus.hi_o, bus.lo_o}, 64'd0);
          return;
        end
      end
      checkOutput("busy_cycles", 64'(cyc), 64'd33);
      checkOutput("hold_hilo", seen, old);
    end else begin
      if (op == 3'd4) model_hi = a;
      if (op == 3'd5) model_lo = a;
      checkOutput("mt_busy", 64'(bus.busy_o), 64'd0);
      checkOutput("mt_value", {bus.hi_o, bus.lo_o}, {model_hi, model_lo});
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected completion within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    bus.start_i = 1'b0;
    bus.op_i    = 3'd0;
    bus.src0_i  = 32'd0;
    bus.src1_i  = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset_hilo", {bus.hi_o, bus.lo_o}, 64'd0);
    checkOutput("reset_busy_done", {62'd0, bus.busy_o, bus.done_o}, 64'd0);

    applyStimulus(3'd0, 32'hFFFF_FFFD, 32'd5, -1, -1);
    applyStimulus(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1);
    applyStimulus(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1);
    applyStimulus(3'd2, 32'hFFFF_FFF9, 32'd2, -1, -1);
    applyStimulus(3'd3, 32'd7, 32'd2, -1, -1);
    applyStimulus(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
    applyStimulus(3'd3, 32'd100, 32'd0, -1, -1);
    applyStimulus(3'd2, 32'hFFFF_FF9C, 32'd0, -1, -1);

    // MTHI then MTLO on consecutive edges.
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.op_i    = 3'd4;
    bus.src0_i  = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    checkOutput("mthi_next_cycle", {bus.hi_o, 31'd0, bus.done_o}, {32'hDEAD_BEEF, 32'd0});
    bus.op_i   = 3'd5;
    bus.src0_i = 32'h1234_5678;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    model_hi = 32'hDEAD_BEEF;
    model_lo = 32'h1234_5678;
    checkOutput("mtlo_next_cycle", {bus.hi_o, bus.lo_o}, {model_hi, model_lo});
    checkOutput("mt_no_done", 64'(bus.done_o), 64'd0);

    applyStimulus(3'd0, 32'd123456, 32'hFFFF_0001, 10, -1);
    applyStimulus(3'd2, 32'd99999, 32'd37, -1, 15);
    repeat (40) @(negedge clk);

    for (int i = 0; i < 30; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1, 2:    rb = 32'($urandom_range(1, 9));
        3:       rb = -32'($urandom_range(1, 9));
        default: rb = $urandom;
      endcase
      applyStimulus(rop, ra, rb, -1, -1);
    end

    repeat (5) @(negedge clk);
    checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/muldiv_hilo.md
# muldiv_hilo

Multi-cycle multiply/divide unit with the architectural HI/LO register pair for the MCPU. It is the sequential counterpart to the ALU's single-cycle combinational mult/div path. The controller issues MULT/MULTU/DIV/DIVU/MTHI/MTLO through a start/busy/done handshake. The 64-bit result is retired into HI/LO, which MFHI/MFLO read directly. It replaces the 32-stage combinational divider chain with a 32-iteration shift/subtract datapath so the MCPU clock is not limited by mult/div depth.

## Interface
- No parameters; the datapath is fixed at 32-bit operands and a 64-bit result.
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- start_i  input  1  request strobe, sampled only when busy_o=0
- op_i  input  3  operation: 3'd0 MULT, 3'd1 MULTU, 3'd2 DIV, 3'd3 DIVU, 3'd4 MTHI, 3'd5 MTLO, 3'd6/3'd7 reserved (no-op)
- src0_i  input  32  rs: multiplicand or dividend, or write data for MTHI/MTLO
- src1_i  input  32  rt: multiplier or divisor
- hi_o  output  32  HI register (remainder or product[63:32])
- lo_o  output  32  LO register (quotient or product[31:0])
- busy_o  output  1  iterative operation in flight
- done_o  output  1  one-cycle pulse: HI/LO were just updated by a mult/div

## Operation
- FSM states: IDLE, CALC, FIX.
- **IDLE**
  - start_i with op 0–3 latches operands and transitions to CALC.
  - Signed ops (0, 2) latch operand magnitudes plus sign flags.
  - Unsigned ops (1, 3) latch operands raw.
  - Reserved ops: no effect.
- **MTHI/MTLO**
  - Accepted only in IDLE.
  - Write src0_i into HI or LO at the accepting edge.
  - No state change, no busy_o, no done_o.
- **CALC**
  - Runs exactly 32 iterations; a 5-bit counter counts 0..31, then the FSM goes to FIX.
  - Multiply: radix-2 shift-add. Each iteration adds the multiplicand into the 33-bit upper accumulator if the multiplier LSB is 1, then shifts the 65-bit {carry, acc, multiplier} right by 1.
  - Divide: restoring division. Shift {rem, quot} left by 1, trial-subtract the divisor from rem using a 33-bit subtract, and keep the difference with quot LSB=1 when non-negative.
- **FIX**
  - Applies sign correction, writes HI/LO, pulses done_o, returns to IDLE.
  - MULT: negate the 64-bit product when the operand signs differ.
  - DIV: negate the quotient when the signs differ; negate the remainder when the dividend is negative.
- **Divide by zero**, all cases:
  - LO = 32'hFFFFFFFF, HI = src0_i as issued (original signed value).
  - Normal 33-cycle latency; no exception.
- **DIV 32'h80000000 / 32'hFFFFFFFF**: LO=32'h80000000, HI=0. This falls out of the magnitude path; no special case is needed.
- **start_i while busy_o=1**: ignored, including MT ops. Operands are never re-sampled mid-operation.
- **rst mid-operation**: FSM goes to IDLE; the counter, HI, LO and done_o are cleared; the partial result is discarded.

## Timing
- **Reset values**: hi_o=0, lo_o=0, busy_o=0, done_o=0, FSM=IDLE.
- **Request**: the start_i/op accept edge is E0.
  - busy_o is high for the 33 cycles after E0, covering 32 CALC and 1 FIX.
  - busy_o is a combinational decode of FSM≠IDLE.
- **Completion**: the FIX edge E33 writes HI/LO.
  - In the cycle after E33: done_o=1, busy_o=0, and hi_o/lo_o show the new values.
- **Back-to-back**: a new start_i in the same cycle as done_o is accepted, giving a 34-cycle issue-to-issue interval.
- **MTHI/MTLO**: the written value is visible on hi_o/lo_o in the cycle after the accepting edge.
- **Output stability**: hi_o/lo_o hold their previous values throughout CALC/FIX until E33; MFHI during busy returns the old value.

## Test plan
- MULT src0=32'hFFFFFFFD (−3), src1=5 -> done_o at E0+34 cycle; HI=32'hFFFFFFFF, LO=32'hFFFFFFF1; busy_o high for exactly 33 cycles.
- MULTU 32'hFFFFFFFF × 32'hFFFFFFFF -> HI=32'hFFFFFFFE, LO=32'h00000001; MULT of the same operands -> HI=0, LO=1.
- DIV −7 / 2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF.
- DIVU 7 / 2 -> LO=3, HI=1.
- DIV 32'h80000000 / 32'hFFFFFFFF -> LO=32'h80000000, HI=0.
- DIVU 100 / 0 -> LO=32'hFFFFFFFF, HI=32'h00000064.
- MTHI 32'hDEADBEEF then MTLO 32'h12345678 on consecutive cycles -> hi_o/lo_o updated one cycle after each, no done_o.
- During a MULT, issue MTLO at cycle 10 -> ignored, LO equals the product.
- Assert rst at cycle 15 of a DIV -> next cycle: busy_o=0, done_o=0, HI=LO=0; no done_o ever follows.
